// File: rtl/mem_stage_sram_pkg.sv
// Shared widths, MEM_BASE default and SRAM access FSM encodings for the MEM stage.
package mem_stage_sram_pkg;

  localparam int REGISTER_LEN     = 32;
  localparam int REG_ADDRESS_LEN  = 4;
  localparam int ADDRESS_LEN      = 32;
  localparam int MEM_BASE_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_stage_sram_if.sv
// 16-bit external SRAM port; master side is the MEM stage, slave side the SRAM.
interface mem_stage_sram_if #(
  parameter int SRAM_ADDR_W = 18
);
  logic [SRAM_ADDR_W-1:0] sram_addr;
  logic [15:0]            sram_dq_out;
  logic [15:0]            sram_dq_in;
  logic                   sram_dq_oe;
  logic                   sram_we_n;

  modport master (output sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, input sram_dq_in);
  modport slave  (input sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, output sram_dq_in);
endinterface

// File: rtl/mem_stage_sram_mem_wb_reg.sv
// MEM/WB pipeline register: loads on ld_i, otherwise inserts a bubble (enables cleared, data held).
module mem_wb_reg
  import mem_stage_sram_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ld_i,
  input  logic                       wb_en_i,
  input  logic                       mem_r_en_i,
  input  logic [REGISTER_LEN-1:0]    alu_res_i,
  input  logic [REGISTER_LEN-1:0]    mem_data_i,
  input  logic [REG_ADDRESS_LEN-1:0] dest_i,
  output logic                       wb_en_o,
  output logic                       mem_r_en_o,
  output logic [REGISTER_LEN-1:0]    alu_res_o,
  output logic [REGISTER_LEN-1:0]    mem_data_o,
  output logic [REG_ADDRESS_LEN-1:0] dest_o
);

  logic                       wb_en_q, mem_r_en_q;
  logic [REGISTER_LEN-1:0]    alu_res_q, mem_data_q;
  logic [REG_ADDRESS_LEN-1:0] dest_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      alu_res_q  <= '0;
      mem_data_q <= '0;
      dest_q     <= '0;
    end else if (ld_i) begin
      wb_en_q    <= wb_en_i;
      mem_r_en_q <= mem_r_en_i;
      alu_res_q  <= alu_res_i;
      mem_data_q <= mem_data_i;
      dest_q     <= dest_i;
    end else begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end
  end

  assign wb_en_o    = wb_en_q;
  assign mem_r_en_o = mem_r_en_q;
  assign alu_res_o  = alu_res_q;
  assign mem_data_o = mem_data_q;
  assign dest_o     = dest_q;

endmodule

// File: rtl/mem_stage_sram.sv
// MEM stage: 32-bit load/store over a 16-bit SRAM (low half first), pipeline stall and MEM/WB register.
// Optional one-entry read buffer enabled by defining MEM_READ_BUF_EN.
module mem_stage_sram
  import mem_stage_sram_pkg::*;
#(
  parameter int MEM_BASE    = MEM_BASE_DEFAULT,
  parameter int SRAM_ADDR_W = 18,
  parameter int SRAM_WAIT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_en_in,
  input  logic                       mem_r_en_in,
  input  logic                       mem_w_en_in,
  input  logic [REGISTER_LEN-1:0]    alu_res_in,
  input  logic [REGISTER_LEN-1:0]    val_Rm_in,
  input  logic [REG_ADDRESS_LEN-1:0] dest_in,
  output logic                       mem_ready,
  output logic                       wb_en_fwd,
  output logic [REG_ADDRESS_LEN-1:0] dest_fwd,
  output logic [REGISTER_LEN-1:0]    wb_value_fwd,
  output logic                       wb_en_out,
  output logic                       mem_r_en_out,
  output logic [REGISTER_LEN-1:0]    alu_res_out,
  output logic [REGISTER_LEN-1:0]    mem_data_out,
  output logic [REG_ADDRESS_LEN-1:0] dest_out,
  mem_stage_sram_if.master           sram
);

  localparam logic [2:0] WAIT_TC = 3'(SRAM_WAIT);

  mem_state_e             state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_c, lo_addr, hi_addr;
  logic [15:0]            rd_lo_q, rd_lo_d, dq_out_c;
  logic [31:0]            rd_word_q, rd_word_d, rel_addr, mem_data_c;
  logic                   req, is_store, buf_hit, in_lo, in_hi, we_n_c, oe_c;
  logic                   unused_addr_bits;

  assign req      = mem_r_en_in | mem_w_en_in;
  assign is_store = mem_w_en_in;
  assign rel_addr = alu_res_in - 32'(MEM_BASE);
  assign lo_addr  = {1'b0, rel_addr[SRAM_ADDR_W-1:2], 1'b0};
  assign hi_addr  = lo_addr | SRAM_ADDR_W'(1);
  assign unused_addr_bits = ^{rel_addr[31:SRAM_ADDR_W], rel_addr[1:0]};

`ifdef MEM_READ_BUF_EN
  logic                   buf_valid_q, buf_match;
  logic [SRAM_ADDR_W-1:0] buf_idx_q;
  logic [31:0]            buf_data_q;

  assign buf_match  = buf_valid_q && (buf_idx_q == lo_addr);
  assign buf_hit    = mem_r_en_in && !mem_w_en_in && (state_q == ST_IDLE) && buf_match;
  assign mem_data_c = buf_hit ? buf_data_q : rd_word_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_q <= 1'b0;
      buf_idx_q   <= '0;
      buf_data_q  <= '0;
    end else if (state_q == ST_DONE) begin
      if (mem_r_en_in && !mem_w_en_in) begin
        buf_valid_q <= 1'b1;
        buf_idx_q   <= lo_addr;
        buf_data_q  <= rd_word_q;
      end else if (is_store && buf_match) begin
        buf_data_q  <= val_Rm_in;
      end
    end
  end
`else
  assign buf_hit    = 1'b0;
  assign mem_data_c = rd_word_q;
`endif

  // The IDLE cycle that sees a request already performs the first LO cycle,
  // so an access stalls exactly 2*(SRAM_WAIT+1) cycles.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_lo_d   = rd_lo_q;
    rd_word_d = rd_word_q;
    addr_c    = addr_q;
    we_n_c    = 1'b1;
    oe_c      = 1'b0;
    dq_out_c  = val_Rm_in[15:0];
    in_lo     = 1'b0;
    in_hi     = 1'b0;
    case (state_q)
      ST_IDLE: in_lo   = req && !buf_hit;
      ST_LO:   in_lo   = 1'b1;
      ST_HI:   in_hi   = 1'b1;
      default: state_d = ST_IDLE;
    endcase
    if (in_lo) begin
      addr_c = lo_addr;
      if (is_store) begin
        we_n_c = 1'b0;
        oe_c   = 1'b1;
      end
      if (cnt_q == WAIT_TC) begin
        state_d = ST_HI;
        cnt_d   = '0;
        if (!is_store) rd_lo_d = sram.sram_dq_in;
      end else begin
        state_d = ST_LO;
        cnt_d   = cnt_q + 3'd1;
      end
    end
    if (in_hi) begin
      addr_c   = hi_addr;
      dq_out_c = val_Rm_in[31:16];
      if (is_store) begin
        we_n_c = 1'b0;
        oe_c   = 1'b1;
      end
      if (cnt_q == WAIT_TC) begin
        state_d = ST_DONE;
        cnt_d   = '0;
        if (!is_store) rd_word_d = {sram.sram_dq_in, rd_lo_q};
      end else begin
        cnt_d = cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_lo_q   <= '0;
      rd_word_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_c;
      rd_lo_q   <= rd_lo_d;
      rd_word_q <= rd_word_d;
    end
  end

  // Strobes are forced inactive while reset is held, even with a request pending.
  assign sram.sram_addr   = rst ? addr_c : '0;
  assign sram.sram_we_n   = we_n_c | ~rst;
  assign sram.sram_dq_oe  = oe_c & rst;
  assign sram.sram_dq_out = dq_out_c;

  assign mem_ready    = !req || (state_q == ST_DONE) || buf_hit;
  assign wb_en_fwd    = wb_en_in;
  assign dest_fwd     = dest_in;
  assign wb_value_fwd = alu_res_in;

  mem_wb_reg u_mem_wb_reg (
    .clk        (clk),
    .rst        (rst),
    .ld_i       (mem_ready),
    .wb_en_i    (wb_en_in),
    .mem_r_en_i (mem_r_en_in),
    .alu_res_i  (alu_res_in),
    .mem_data_i (mem_data_c),
    .dest_i     (dest_in),
    .wb_en_o    (wb_en_out),
    .mem_r_en_o (mem_r_en_out),
    .alu_res_o  (alu_res_out),
    .mem_data_o (mem_data_out),
    .dest_o     (dest_out)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: one DUT at SRAM_WAIT=1, one at SRAM_WAIT=0, each with a small SRAM model.
module tb_mem_stage_sram;
  import mem_stage_sram_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_Rm_in;
  logic [3:0]  dest_in;

  logic        mem_ready, wb_en_fwd, wb_en_out, mem_r_en_out;
  logic [3:0]  dest_fwd, dest_out;
  logic [31:0] wb_value_fwd, alu_res_out, mem_data_out;

  logic        z_mem_ready, z_wb_en_fwd, z_wb_en_out, z_mem_r_en_out;
  logic [3:0]  z_dest_fwd, z_dest_out;
  logic [31:0] z_wb_value_fwd, z_alu_res_out, z_mem_data_out;

  int n_run  = 0;
  int n_fail = 0;
  int wr0_cnt = 0;

  mem_stage_sram_if #(.SRAM_ADDR_W(18)) s1 ();
  mem_stage_sram_if #(.SRAM_ADDR_W(18)) s0 ();

  logic [15:0] mem1 [0:255];
  logic [15:0] mem0 [0:255];

  assign s1.sram_dq_in = mem1[s1.sram_addr[7:0]];
  assign s0.sram_dq_in = mem0[s0.sram_addr[7:0]];

  always @(posedge clk) begin
    if (!s1.sram_we_n) mem1[s1.sram_addr[7:0]] = s1.sram_dq_out;
    if (!s0.sram_we_n) begin
      mem0[s0.sram_addr[7:0]] = s0.sram_dq_out;
      wr0_cnt = wr0_cnt + 1;
    end
  end

  mem_stage_sram #(.MEM_BASE(1024), .SRAM_ADDR_W(18), .SRAM_WAIT(1)) dut (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
    .mem_ready(mem_ready), .wb_en_fwd(wb_en_fwd), .dest_fwd(dest_fwd), .wb_value_fwd(wb_value_fwd),
    .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out),
    .sram(s1.master)
  );

  mem_stage_sram #(.MEM_BASE(1024), .SRAM_ADDR_W(18), .SRAM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .alu_res_in(alu_res_in), .val_Rm_in(val_Rm_in), .dest_in(dest_in),
    .mem_ready(z_mem_ready), .wb_en_fwd(z_wb_en_fwd), .dest_fwd(z_dest_fwd), .wb_value_fwd(z_wb_value_fwd),
    .wb_en_out(z_wb_en_out), .mem_r_en_out(z_mem_r_en_out), .alu_res_out(z_alu_res_out),
    .mem_data_out(z_mem_data_out), .dest_out(z_dest_out),
    .sram(s0.master)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic wb, input logic r, input logic w,
                       input logic [31:0] alu, input logic [31:0] val, input logic [3:0] d);
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_Rm_in = val; dest_in = d;
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (n) step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle(2);
    n_run++;
    if (mem_ready !== 1'b1 || s1.sram_we_n !== 1'b1 || s1.sram_dq_oe !== 1'b0 || s1.sram_addr !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_sram: ready=%b we_n=%b oe=%b addr=%0d, want 1 1 0 0",
               mem_ready, s1.sram_we_n, s1.sram_dq_oe, s1.sram_addr);
    end
    n_run++;
    if ({wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_memwb: wb=%b r=%b alu=%h data=%h dest=%h, want all zero",
               wb_en_out, mem_r_en_out, alu_res_out, mem_data_out, dest_out);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_non_mem();
    drive(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3);
    n_run++;
    if (mem_ready !== 1'b1 || wb_value_fwd !== 32'h55 || wb_en_fwd !== 1'b1 || dest_fwd !== 4'd3) begin
      n_fail++;
      $display("FAIL nonmem_fwd: ready=%b val=%h wb=%b dest=%0d, want 1 55 1 3",
               mem_ready, wb_value_fwd, wb_en_fwd, dest_fwd);
    end
    step();
    n_run++;
    if (alu_res_out !== 32'h55 || dest_out !== 4'd3 || wb_en_out !== 1'b1 || mem_r_en_out !== 1'b0) begin
      n_fail++;
      $display("FAIL nonmem_memwb: alu=%h dest=%0d wb=%b r=%b, want 55 3 1 0",
               alu_res_out, dest_out, wb_en_out, mem_r_en_out);
    end
  endtask

  task automatic test_store();
    logic [17:0] ea;
    logic [15:0] ed;
    drive(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 4'd0);
    for (int c = 0; c < 4; c++) begin
      ea = (c < 2) ? 18'd4 : 18'd5;
      ed = (c < 2) ? 16'hBEEF : 16'hDEAD;
      n_run++;
      if (mem_ready !== 1'b0 || s1.sram_we_n !== 1'b0 || s1.sram_dq_oe !== 1'b1 ||
          s1.sram_addr !== ea || s1.sram_dq_out !== ed) begin
        n_fail++;
        $display("FAIL store_cyc%0d: ready=%b we_n=%b oe=%b addr=%0d dq=%h, want 0 0 1 %0d %h",
                 c, mem_ready, s1.sram_we_n, s1.sram_dq_oe, s1.sram_addr, s1.sram_dq_out, ea, ed);
      end
      if (c > 0) begin
        n_run++;
        if (wb_en_out !== 1'b0) begin
          n_fail++;
          $display("FAIL store_bubble%0d: wb_en_out=%b, want 0", c, wb_en_out);
        end
      end
      step();
    end
    n_run++;
    if (mem_ready !== 1'b1 || s1.sram_we_n !== 1'b1 || s1.sram_dq_oe !== 1'b0 || s1.sram_addr !== 18'd5) begin
      n_fail++;
      $display("FAIL store_done: ready=%b we_n=%b oe=%b addr=%0d, want 1 1 0 5",
               mem_ready, s1.sram_we_n, s1.sram_dq_oe, s1.sram_addr);
    end
    step();
    idle(1);
    n_run++;
    if (mem1[4] !== 16'hBEEF || mem1[5] !== 16'hDEAD) begin
      n_fail++;
      $display("FAIL store_mem: m4=%h m5=%h, want beef dead", mem1[4], mem1[5]);
    end
  endtask

  task automatic test_load();
    logic [17:0] ea;
    mem1[4] = 16'hBEEF;
    mem1[5] = 16'hDEAD;
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7);
    for (int c = 0; c < 4; c++) begin
      ea = (c < 2) ? 18'd4 : 18'd5;
      n_run++;
      if (mem_ready !== 1'b0 || s1.sram_we_n !== 1'b1 || s1.sram_dq_oe !== 1'b0 || s1.sram_addr !== ea) begin
        n_fail++;
        $display("FAIL load_cyc%0d: ready=%b we_n=%b oe=%b addr=%0d, want 0 1 0 %0d",
                 c, mem_ready, s1.sram_we_n, s1.sram_dq_oe, s1.sram_addr, ea);
      end
      if (c > 0) begin
        n_run++;
        if (wb_en_out !== 1'b0) begin
          n_fail++;
          $display("FAIL load_bubble%0d: wb_en_out=%b, want 0", c, wb_en_out);
        end
      end
      step();
    end
    n_run++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done: ready=%b, want 1", mem_ready);
    end
    step();
    n_run++;
    if (mem_data_out !== 32'hDEADBEEF || wb_en_out !== 1'b1 || mem_r_en_out !== 1'b1 ||
        dest_out !== 4'd7 || alu_res_out !== 32'd1032) begin
      n_fail++;
      $display("FAIL load_memwb: data=%h wb=%b r=%b dest=%0d alu=%0d, want deadbeef 1 1 7 1032",
               mem_data_out, wb_en_out, mem_r_en_out, dest_out, alu_res_out);
    end
    idle(1);
  endtask

  task automatic test_reset_mid();
    int n;
    drive(1'b0, 1'b0, 1'b1, 32'd1040, 32'hCAFEF00D, 4'd0);
    step();
    step();
    n_run++;
    if (s1.sram_we_n !== 1'b0 || s1.sram_addr !== 18'd9) begin
      n_fail++;
      $display("FAIL midrst_pre: we_n=%b addr=%0d, want 0 9", s1.sram_we_n, s1.sram_addr);
    end
    rst = 1'b0;
    #1;
    n_run++;
    if (s1.sram_we_n !== 1'b1 || s1.sram_dq_oe !== 1'b0 || s1.sram_addr !== 18'd0 || mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_now: we_n=%b oe=%b addr=%0d ready=%b, want 1 0 0 0",
               s1.sram_we_n, s1.sram_dq_oe, s1.sram_addr, mem_ready);
    end
    idle(2);
    rst = 1'b1;
    step();
    drive(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd9);
    n = 0;
    while (mem_ready === 1'b0 && n < 10) begin
      step();
      n++;
    end
    n_run++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL midrst_stall: stalled %0d cycles, want 4", n);
    end
    step();
    n_run++;
    if (mem_data_out !== 32'hDEADBEEF || wb_en_out !== 1'b1 || dest_out !== 4'd9) begin
      n_fail++;
      $display("FAIL midrst_load: data=%h wb=%b dest=%0d, want deadbeef 1 9", mem_data_out, wb_en_out, dest_out);
    end
    idle(2);
  endtask

`ifdef MEM_READ_BUF_EN
  task automatic test_read_buf();
    int n;
    mem1[12] = 16'h3333;
    mem1[13] = 16'h4444;
    drive(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd2);
    n = 0;
    while (mem_ready === 1'b0 && n < 10) begin
      step();
      n++;
    end
    n_run++;
    if (n !== 4) begin
      n_fail++;
      $display("FAIL buf_miss_stall: stalled %0d cycles, want 4", n);
    end
    step();
    drive(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd2);
    n_run++;
    if (mem_ready !== 1'b1 || s1.sram_we_n !== 1'b1 || s1.sram_addr !== 18'd13) begin
      n_fail++;
      $display("FAIL buf_hit_now: ready=%b we_n=%b addr=%0d, want 1 1 13", mem_ready, s1.sram_we_n, s1.sram_addr);
    end
    step();
    n_run++;
    if (mem_data_out !== 32'h44443333 || wb_en_out !== 1'b1) begin
      n_fail++;
      $display("FAIL buf_hit_data: data=%h wb=%b, want 44443333 1", mem_data_out, wb_en_out);
    end
    drive(1'b0, 1'b0, 1'b1, 32'd1048, 32'h12345678, 4'd0);
    n = 0;
    while (mem_ready === 1'b0 && n < 10) begin
      step();
      n++;
    end
    step();
    drive(1'b1, 1'b1, 1'b0, 32'd1048, 32'h0, 4'd4);
    n_run++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL buf_st_hit: ready=%b, want 1", mem_ready);
    end
    step();
    n_run++;
    if (mem_data_out !== 32'h12345678) begin
      n_fail++;
      $display("FAIL buf_st_data: data=%h, want 12345678", mem_data_out);
    end
    idle(2);
  endtask
`endif

  task automatic test_wait0_b2b();
    int wr_start;
    idle(12);
    mem0[16] = 16'h1111;
    mem0[17] = 16'h2222;
    wr_start = wr0_cnt;
    drive(1'b1, 1'b1, 1'b0, 32'd1056, 32'h0, 4'd5);
    n_run++;
    if (z_mem_ready !== 1'b0 || s0.sram_addr !== 18'd16) begin
      n_fail++;
      $display("FAIL w0_ld0: ready=%b addr=%0d, want 0 16", z_mem_ready, s0.sram_addr);
    end
    step();
    n_run++;
    if (z_mem_ready !== 1'b0 || s0.sram_addr !== 18'd17) begin
      n_fail++;
      $display("FAIL w0_ld1: ready=%b addr=%0d, want 0 17", z_mem_ready, s0.sram_addr);
    end
    step();
    n_run++;
    if (z_mem_ready !== 1'b1 || s0.sram_we_n !== 1'b1) begin
      n_fail++;
      $display("FAIL w0_ld_done: ready=%b we_n=%b, want 1 1", z_mem_ready, s0.sram_we_n);
    end
    step();
    drive(1'b0, 1'b0, 1'b1, 32'd1060, 32'hA5A55A5A, 4'd0);
    n_run++;
    if (z_mem_data_out !== 32'h22221111 || z_wb_en_out !== 1'b1 || z_dest_out !== 4'd5) begin
      n_fail++;
      $display("FAIL w0_ld_data: data=%h wb=%b dest=%0d, want 22221111 1 5", z_mem_data_out, z_wb_en_out, z_dest_out);
    end
    n_run++;
    if (z_mem_ready !== 1'b0 || s0.sram_we_n !== 1'b0 || s0.sram_addr !== 18'd18 || s0.sram_dq_out !== 16'h5A5A) begin
      n_fail++;
      $display("FAIL w0_st0: ready=%b we_n=%b addr=%0d dq=%h, want 0 0 18 5a5a",
               z_mem_ready, s0.sram_we_n, s0.sram_addr, s0.sram_dq_out);
    end
    step();
    n_run++;
    if (z_mem_ready !== 1'b0 || s0.sram_we_n !== 1'b0 || s0.sram_addr !== 18'd19 || s0.sram_dq_out !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL w0_st1: ready=%b we_n=%b addr=%0d dq=%h, want 0 0 19 a5a5",
               z_mem_ready, s0.sram_we_n, s0.sram_addr, s0.sram_dq_out);
    end
    step();
    n_run++;
    if (z_mem_ready !== 1'b1 || s0.sram_we_n !== 1'b1) begin
      n_fail++;
      $display("FAIL w0_st_done: ready=%b we_n=%b, want 1 1", z_mem_ready, s0.sram_we_n);
    end
    step();
    idle(2);
    n_run++;
    if (mem0[18] !== 16'h5A5A || mem0[19] !== 16'hA5A5 || mem0[16] !== 16'h1111 || wr0_cnt - wr_start !== 2) begin
      n_fail++;
      $display("FAIL w0_mem: m18=%h m19=%h m16=%h writes=%0d, want 5a5a a5a5 1111 2",
               mem0[18], mem0[19], mem0[16], wr0_cnt - wr_start);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0;
      mem0[i] = 16'h0;
    end
    test_reset();
    test_non_mem();
    test_store();
    test_load();
    test_reset_mid();
`ifdef MEM_READ_BUF_EN
    test_read_buf();
`endif
    test_wait0_b2b();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
